lj_force_accumulator: RTL and testbench

//  Consumes the per-pair LJ force stream (valid + data_tuple_t) from the LJ pair evaluator.

---
 rtl/lj_force_accumulator.sv | 251 +++++++++++++++++++++++++
 tb/tb_lj_force_accumulator.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/lj_force_accumulator.sv
// LJ force accumulator: sums the per-pair force stream of one reference particle through
// three-stage pipelined single-precision adders (one per axis) and emits the total force.
package md_pkg;
  localparam int DATA_WIDTH = 32;
  typedef struct packed {
    logic [DATA_WIDTH-1:0] x;
    logic [DATA_WIDTH-1:0] y;
    logic [DATA_WIDTH-1:0] z;
  } data_tuple_t;
endpackage

// Three-register IEEE single adder: align, add/sub, normalize+round (RNE). Subnormals flush to zero.
module lj_fp_add (
  input  logic        clk,
  input  logic        clr,
  input  logic        ena,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] y_o
);
  logic [31:0] big, sml;
  logic        s1_sgn_q, s1_sub_q;
  logic [7:0]  s1_exp_q, s1_dif_q;
  logic [23:0] s1_mb_q, s1_ms_q;
  logic [27:0] s2_sum_q;
  logic [7:0]  s2_exp_q;
  logic        s2_sgn_q, s2_sub_q;
  logic [31:0] y_q, y_d;
  logic [4:0]  dcap, lz;
  logic [50:0] ext;
  logic [26:0] al, nrm;
  logic [27:0] sum;
  logic [24:0] mr;
  logic        rup;
  logic signed [9:0] e, e2;

  assign big = (b_i[30:0] > a_i[30:0]) ? b_i : a_i;
  assign sml = (b_i[30:0] > a_i[30:0]) ? a_i : b_i;

  always_comb begin
    dcap = (s1_dif_q > 8'd27) ? 5'd27 : s1_dif_q[4:0];
    ext  = {s1_ms_q, 27'b0} >> dcap;
    al   = {ext[50:25], |ext[24:0]};
    sum  = s1_sub_q ? ({1'b0, s1_mb_q, 3'b0} - {1'b0, al})
                    : ({1'b0, s1_mb_q, 3'b0} + {1'b0, al});
  end

  always_comb begin
    lz = 5'd27;
    for (int i = 0; i < 27; i++)
      if (s2_sum_q[i]) lz = 5'(26 - i);
    if (s2_sum_q[27]) begin
      nrm = {s2_sum_q[27:2], s2_sum_q[1] | s2_sum_q[0]};
      e   = $signed({2'b0, s2_exp_q}) + 10'sd1;
    end else begin
      nrm = s2_sum_q[26:0] << lz;
      e   = $signed({2'b0, s2_exp_q}) - $signed({5'b0, lz});
    end
    rup = nrm[2] & (nrm[1] | nrm[0] | nrm[3]);
    mr  = {1'b0, nrm[26:3]} + {24'b0, rup};
    e2  = e + $signed({9'b0, mr[24]});
    if (s2_sum_q == '0)         y_d = {s2_sgn_q & ~s2_sub_q, 31'b0};
    else if (e2 <= 10'sd0)      y_d = {s2_sgn_q, 31'b0};
    else if (e2 >= 10'sd255)    y_d = {s2_sgn_q, 8'hff, 23'b0};
    else                        y_d = {s2_sgn_q, e2[7:0], mr[24] ? mr[23:1] : mr[22:0]};
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      s1_sgn_q <= 1'b0; s1_sub_q <= 1'b0; s1_exp_q <= '0; s1_dif_q <= '0;
      s1_mb_q  <= '0;   s1_ms_q  <= '0;
      s2_sum_q <= '0;   s2_exp_q <= '0;   s2_sgn_q <= 1'b0; s2_sub_q <= 1'b0;
      y_q      <= '0;
    end else if (ena) begin
      s1_sgn_q <= big[31];
      s1_sub_q <= big[31] ^ sml[31];
      s1_exp_q <= big[30:23];
      s1_dif_q <= big[30:23] - sml[30:23];
      s1_mb_q  <= (big[30:23] == 8'd0) ? 24'd0 : {1'b1, big[22:0]};
      s1_ms_q  <= (sml[30:23] == 8'd0) ? 24'd0 : {1'b1, sml[22:0]};
      s2_sum_q <= sum;
      s2_exp_q <= s1_exp_q;
      s2_sgn_q <= s1_sgn_q;
      s2_sub_q <= s1_sub_q;
      y_q      <= y_d;
    end
  end

  assign y_o = y_q;
endmodule

module lj_force_accumulator
  import md_pkg::*;
#(
  parameter int ID_WIDTH  = 16,
  parameter int CNT_WIDTH = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 force_valid,
  input  data_tuple_t          force_in,
  input  logic                 force_last,
  input  logic [ID_WIDTH-1:0]  force_ref_id,
  output logic                 acc_ready,
  output data_tuple_t          acc_out,
  output logic [ID_WIDTH-1:0]  acc_ref_id,
  output logic [CNT_WIDTH-1:0] acc_pair_cnt,
  output logic                 acc_valid,
  input  logic                 out_ready,
  output logic                 drop_err
);
  localparam int NAX = 3;
  typedef logic [NAX-1:0][DATA_WIDTH-1:0] vec_t;
  typedef enum logic [2:0] {IDLE, ACCUM, DRAIN, RED1, RED2, OUT} state_t;

  state_t               state_q, state_d;
  logic [1:0]           slot_q, slot_d, ph_q, ph_d, slot_inc;
  logic [ID_WIDTH-1:0]  id_q, id_d, out_id_q, out_id_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d, out_cnt_q, out_cnt_d;
  logic [2:0][NAX-1:0][DATA_WIDTH-1:0] lane_q, lane_d;
  vec_t                 out_sum_q, out_sum_d, fin, ax, ay, res, res_m;
  logic                 drop_q, drop_d, accept, iss_vld, ena;
  logic [3:1]           vld_pipe_q;

  assign fin       = force_in;
  assign acc_ready = (state_q == IDLE) || (state_q == ACCUM);
  assign accept    = force_valid & acc_ready;
  assign slot_inc  = (slot_q == 2'd2) ? 2'd0 : slot_q + 2'd1;
  // Results whose issue slot carried no live partial sum read as +0.0.
  assign res_m     = vld_pipe_q[3] ? res : '0;
  assign ena       = (state_q != IDLE) | accept;

  for (genvar g = 0; g < NAX; g++) begin : g_ax
    lj_fp_add u_add (
      .clk(clk), .clr(rst), .ena(ena),
      .a_i(ax[g]), .b_i(ay[g]), .y_o(res[g])
    );
  end

  always_comb begin
    state_d   = state_q;
    slot_d    = slot_q;
    ph_d      = ph_q;
    id_d      = id_q;
    cnt_d     = cnt_q;
    lane_d    = lane_q;
    out_sum_d = out_sum_q;
    out_id_d  = out_id_q;
    out_cnt_d = out_cnt_q;
    drop_d    = drop_q | (force_valid & ~acc_ready);
    ax        = '0;
    ay        = '0;
    iss_vld   = 1'b0;
    case (state_q)
      IDLE: begin
        slot_d = 2'd0;
        ph_d   = 2'd0;
        if (accept) begin
          ax      = fin;
          iss_vld = 1'b1;
          id_d    = force_ref_id;
          cnt_d   = CNT_WIDTH'(1);
          slot_d  = 2'd1;
          state_d = force_last ? DRAIN : ACCUM;
        end
      end
      ACCUM: begin
        ax      = accept ? fin : '0;
        ay      = res_m;
        iss_vld = 1'b1;
        slot_d  = slot_inc;
        if (accept) begin
          cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_WIDTH'(1);
          if (force_last) state_d = DRAIN;
        end
      end
      DRAIN: begin
        lane_d[slot_q] = res_m;
        slot_d = slot_inc;
        ph_d   = ph_q + 2'd1;
        if (ph_q == 2'd2) begin
          state_d = RED1;
          ph_d    = 2'd0;
        end
      end
      RED1: begin
        ax      = lane_q[0];
        ay      = lane_q[1];
        iss_vld = (ph_q == 2'd0);
        ph_d    = ph_q + 2'd1;
        if (ph_q == 2'd2) begin
          state_d = RED2;
          ph_d    = 2'd0;
        end
      end
      RED2: begin
        ax      = res;
        ay      = lane_q[2];
        iss_vld = (ph_q == 2'd0);
        ph_d    = ph_q + 2'd1;
        if (ph_q == 2'd3) begin
          out_sum_d = res;
          out_id_d  = id_q;
          out_cnt_d = cnt_q;
          state_d   = OUT;
        end
      end
      OUT: begin
        if (out_ready) begin
          state_d = IDLE;
          slot_d  = 2'd0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      slot_q     <= '0;
      ph_q       <= '0;
      id_q       <= '0;
      cnt_q      <= '0;
      lane_q     <= '0;
      out_sum_q  <= '0;
      out_id_q   <= '0;
      out_cnt_q  <= '0;
      drop_q     <= 1'b0;
      vld_pipe_q <= '0;
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      ph_q       <= ph_d;
      id_q       <= id_d;
      cnt_q      <= cnt_d;
      lane_q     <= lane_d;
      out_sum_q  <= out_sum_d;
      out_id_q   <= out_id_d;
      out_cnt_q  <= out_cnt_d;
      drop_q     <= drop_d;
      if (ena) vld_pipe_q <= {vld_pipe_q[2:1], iss_vld};
    end
  end

  assign acc_out      = out_sum_q;
  assign acc_ref_id   = out_id_q;
  assign acc_pair_cnt = out_cnt_q;
  assign acc_valid    = (state_q == OUT);
  assign drop_err     = drop_q;
endmodule

// File: tb/tb_lj_force_accumulator.sv
// Bench for lj_force_accumulator: directed cases plus random particles whose pair values are
// multiples of 0.25, so the expected total is an exact integer sum independent of add order.
module tb_lj_force_accumulator;
  logic        clk = 1'b0;
  logic        rst;
  logic        force_valid, force_last, out_ready;
  md_pkg::data_tuple_t force_in, acc_out;
  logic [15:0] force_ref_id, acc_ref_id;
  logic [9:0]  acc_pair_cnt;
  logic        acc_ready, acc_valid, drop_err;
  int          nchk = 0, nerr = 0;

  lj_force_accumulator #(.ID_WIDTH(16), .CNT_WIDTH(10)) dut (
    .clk(clk), .rst(rst),
    .force_valid(force_valid), .force_in(force_in), .force_last(force_last),
    .force_ref_id(force_ref_id),
    .acc_ready(acc_ready), .acc_out(acc_out), .acc_ref_id(acc_ref_id),
    .acc_pair_cnt(acc_pair_cnt), .acc_valid(acc_valid), .out_ready(out_ready),
    .drop_err(drop_err)
  );

  always #5 clk = ~clk;

  // Float bits of q/4 (|q| < 2^23).
  function automatic logic [31:0] q2f(input int q);
    int m, p;
    logic [31:0] mm;
    if (q == 0) return 32'h0;
    m = (q < 0) ? -q : q;
    p = 0;
    for (int i = 0; i < 31; i++) if (m[i]) p = i;
    mm = m << (23 - p);
    return {q < 0, 8'(p + 125), mm[22:0]};
  endfunction

  function automatic logic [95:0] tup(input int qx, input int qy, input int qz);
    return {q2f(qx), q2f(qy), q2f(qz)};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input int qx, input int qy, input int qz, input bit last,
                      input logic [15:0] id, input int gap);
    force_in     = tup(qx, qy, qz);
    force_valid  = 1'b1;
    force_last   = last;
    force_ref_id = id;
    @(posedge clk); #1;
    force_valid = 1'b0;
    force_last  = 1'b0;
    force_in    = '0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".valid"}, acc_valid, 1'b0);
    chk({tag, ".drop"},  drop_err, 1'b0);
    chk({tag, ".out"},   acc_out, 96'h0);
    chk({tag, ".id"},    acc_ref_id, 16'h0);
    chk({tag, ".cnt"},   acc_pair_cnt, 10'h0);
    chk({tag, ".ready"}, acc_ready, 1'b1);
  endtask

  // Called right after the accepting edge of the last pair (or exp_lat edges before acc_valid).
  task automatic expect_out(input string tag, input logic [95:0] exp_sum, input logic [15:0] exp_id,
                            input logic [9:0] exp_cnt, input int exp_lat, input int stall);
    int k;
    out_ready = (stall == 0);
    k = 0;
    while (!acc_valid && k < 40) begin @(posedge clk); #1; k++; end
    chk({tag, ".lat"},   k, exp_lat);
    chk({tag, ".sum"},   acc_out, exp_sum);
    chk({tag, ".id"},    acc_ref_id, exp_id);
    chk({tag, ".cnt"},   acc_pair_cnt, exp_cnt);
    chk({tag, ".rdy0"},  acc_ready, 1'b0);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      chk({tag, ".hold"}, {acc_valid, acc_out, acc_ready, acc_ref_id}, {1'b1, exp_sum, 1'b0, exp_id});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk({tag, ".done"}, {acc_valid, acc_ready}, 2'b01);
  endtask

  initial begin
    int n, sx, sy, sz, qx, qy, qz, gap, stall;
    logic [15:0] rid;
    rst = 1'b1; force_valid = 1'b0; force_last = 1'b0; force_in = '0;
    force_ref_id = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_reset("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    send(4, -8, 2, 1'b1, 16'h1234, 0);
    expect_out("single", tup(4, -8, 2), 16'h1234, 10'd1, 10, 0);

    send(4, 4, 4, 1'b0, 16'hA001, 0);
    send(8, 8, 8, 1'b0, 16'hA002, 0);
    send(12, 12, 12, 1'b0, 16'hA003, 0);
    send(16, 16, 16, 1'b1, 16'hA004, 0);
    expect_out("b2b4", tup(40, 40, 40), 16'hA001, 10'd4, 10, 0);

    for (int i = 0; i < 5; i++) send(4, 4, 4, i == 4, 16'h0055, (i == 4) ? 0 : i);
    expect_out("gaps", tup(20, 20, 20), 16'h0055, 10'd5, 10, 0);

    send(-6, 3, 1, 1'b0, 16'h0777, 0);
    send(2, 5, -1, 1'b0, 16'h0777, 1);
    send(1, 1, 1, 1'b1, 16'h0777, 0);
    expect_out("stall", tup(-3, 9, 1), 16'h0777, 10'd3, 10, 7);

    send(4, 4, 4, 1'b0, 16'h0D0D, 0);
    send(8, 8, 8, 1'b1, 16'h0D0D, 0);
    repeat (3) begin @(posedge clk); #1; end
    chk("drop.pre", {acc_ready, drop_err}, 2'b00);
    force_valid = 1'b1; force_in = tup(400, 400, 400); force_ref_id = 16'hBAD0;
    @(posedge clk); #1;
    force_valid = 1'b0; force_in = '0;
    chk("drop.set", drop_err, 1'b1);
    expect_out("drop", tup(12, 12, 12), 16'h0D0D, 10'd2, 6, 0);
    chk("drop.sticky", drop_err, 1'b1);

    for (int i = 0; i < 3; i++) send(4, 4, 4, 1'b0, 16'h5555, 0);
    rst = 1'b1;
    #2;
    chk_reset("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    send(8, 8, 8, 1'b0, 16'h2222, 0);
    send(8, 8, 8, 1'b1, 16'h2223, 0);
    expect_out("postrst", tup(16, 16, 16), 16'h2222, 10'd2, 10, 0);

    for (int p = 0; p < 20; p++) begin
      n = $urandom_range(1, 8);
      rid = 16'($urandom);
      stall = $urandom_range(0, 3);
      sx = 0; sy = 0; sz = 0;
      for (int i = 0; i < n; i++) begin
        qx = $urandom_range(0, 128) - 64;
        qy = $urandom_range(0, 128) - 64;
        qz = $urandom_range(0, 128) - 64;
        sx += qx; sy += qy; sz += qz;
        gap = (i == n - 1) ? 0 : $urandom_range(0, 3);
        send(qx, qy, qz, i == n - 1, (i == 0) ? rid : 16'($urandom), gap);
      end
      expect_out("rand", tup(sx, sy, sz), rid, 10'(n), 10, stall);
    end
    chk("rand.nodrop", drop_err, 1'b0);

    for (int i = 0; i < 1030; i++) send(1, -1, 0, i == 1029, 16'h0BEE, 0);
    expect_out("sat", tup(1030, -1030, 0), 16'h0BEE, 10'h3FF, 10, 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
